// File: rtl/i2s_tx_slave_if.sv
// Producer-side stereo sample handshake for the I2S slave transmitter.
// The producer offers a {left,right} pair; the transmitter accepts it when ready.
`timescale 1ns/1ps
interface i2s_tx_slave_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] sample_left;
    logic [DATA_W-1:0] sample_right;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output sample_left,
        output sample_right,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_left,
        input  sample_right,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/i2s_tx_slave.sv
// I2S (Philips) slave transmitter: codec drives SCLK/LRCLK, we drive DIN.
// Stereo pairs are buffered in a small FIFO and popped at each left-frame start.
`timescale 1ns/1ps
module i2s_tx_slave #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             enable,
    i2s_tx_slave_if.slave                    smp,
    input  logic                             i2s_sclk,
    input  logic                             i2s_lrclk,
    output logic                             i2s_din,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
    output logic                             underrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_W);

    typedef enum logic [1:0] {
        UNLOCKED,
        LEFT,
        RIGHT
    } state_t;

    logic sclk_s1, sclk_s2, sclk_s3;
    logic lr_s1, lr_s2, lr_s3;
    logic sclk_rise, sclk_fall;
    logic lr_q;

    logic boundary, left_bnd, right_bnd;

    state_t state_q, state_d;
    logic   frame_start;
    logic   pop, push, empty, urun;

    logic [DATA_W-1:0] mem_l [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;

    logic [DATA_W-1:0] shl, shr;
    logic [CW-1:0]     bitcnt;

    // Two flops for metastability, a third for edge detection; strobes registered.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sclk_s1   <= 1'b0;
            sclk_s2   <= 1'b0;
            sclk_s3   <= 1'b0;
            lr_s1     <= 1'b0;
            lr_s2     <= 1'b0;
            lr_s3     <= 1'b0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
        end else begin
            sclk_s1   <= i2s_sclk;
            sclk_s2   <= sclk_s1;
            sclk_s3   <= sclk_s2;
            lr_s1     <= i2s_lrclk;
            lr_s2     <= lr_s1;
            lr_s3     <= lr_s2;
            sclk_rise <= sclk_s2 & ~sclk_s3;
            sclk_fall <= ~sclk_s2 & sclk_s3;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lr_q <= 1'b0;
        end else if (sclk_rise) begin
            lr_q <= lr_s3;
        end
    end

    assign boundary  = sclk_rise && (lr_s3 != lr_q);
    assign left_bnd  = boundary && !lr_s3;
    assign right_bnd = boundary && lr_s3;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= UNLOCKED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        if (!enable) begin
            state_d = UNLOCKED;
        end else begin
            frame_start = left_bnd;
            unique case (state_q)
                UNLOCKED: if (left_bnd)  state_d = LEFT;
                LEFT:     if (right_bnd) state_d = RIGHT;
                RIGHT:    if (left_bnd)  state_d = LEFT;
                default:                 state_d = UNLOCKED;
            endcase
        end
    end

    assign empty = (fifo_level == '0);
    assign pop   = frame_start && !empty;
    assign urun  = frame_start && empty;

    assign smp.sample_ready = reset_n && (fifo_level != FULL);
    assign push             = smp.sample_valid && smp.sample_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_l[wr_ptr] <= smp.sample_left;
            mem_r[wr_ptr] <= smp.sample_right;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + 1'b1;
            end else if (pop && !push) begin
                fifo_level <= fifo_level - 1'b1;
            end
        end
    end

    // Shift registers empty out to zero, so long slots pad with zeros.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shl      <= '0;
            shr      <= '0;
            bitcnt   <= '0;
            i2s_din  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            underrun <= urun;
            if (state_d == UNLOCKED) begin
                i2s_din <= 1'b0;
                bitcnt  <= '0;
            end else if (frame_start) begin
                shl    <= pop ? mem_l[rd_ptr] : '0;
                shr    <= pop ? mem_r[rd_ptr] : '0;
                bitcnt <= '0;
            end else if (right_bnd) begin
                bitcnt <= '0;
            end else if (sclk_fall && state_q != UNLOCKED) begin
                if (bitcnt < LAST) begin
                    bitcnt <= bitcnt + 1'b1;
                    if (state_q == LEFT) begin
                        i2s_din <= shl[DATA_W-1];
                        shl     <= {shl[DATA_W-2:0], 1'b0};
                    end else begin
                        i2s_din <= shr[DATA_W-1];
                        shr     <= {shr[DATA_W-2:0], 1'b0};
                    end
                end else begin
                    i2s_din <= 1'b0;
                end
            end
        end
    end

endmodule
